// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed N-digit 7-segment driver. A prescaler holds each digit lit
//   for REFRESH_DIV clocks, then advances a digit index that wraps DIGITS-1 -> 0.
//   New display data is captured by `load` into a pending register and promoted
//   to the active register only at the frame wrap, so a frame never mixes old and
//   new digits.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   load       : one-cycle strobe, captures value/dp_mask into the pending register
//   value      : packed nibbles, nibble 0 (bits [3:0]) is the rightmost digit
//   dp_mask    : per-digit decimal point request, bit i -> digit i
//   hex_mode   : 1 = nibbles 10..15 shown as A,b,C,d,E,F; 0 = shown as dash
//   blank_lz   : 1 = blank leading zero digits (digit 0 is never blanked)
//   seg        : registered segment drive, bit0=a .. bit6=g, bit7=dp
//   an         : registered one-hot (or one-cold) digit enable
//   frame_done : high during the cycle on which the index wraps to digit 0
//   pending    : high while loaded data waits for the next frame boundary
//
// Parameters
//   DIGITS         : digit count, 1..8
//   REFRESH_DIV    : clocks per digit, >= 2
//   SEG_ACTIVE_LOW : invert seg at the output register
//   AN_ACTIVE_LOW  : invert an at the output register

module seg7_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRESC_MAX  = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     IDX_MAX    = IW'(DIGITS - 1);
    localparam logic [7:0]        SEG_RESET  = SEG_ACTIVE_LOW ? 8'hC0 : 8'h3F;
    localparam logic [DIGITS-1:0] AN_DIGIT0  = DIGITS'(1);
    localparam logic [DIGITS-1:0] AN_RESET   = AN_ACTIVE_LOW ? ~AN_DIGIT0 : AN_DIGIT0;

    // Scan state
    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;

    // Double-buffered display data
    logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                  pending_q, pending_d;
    logic [4*DIGITS-1:0]   act_val_q, act_val_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d;

    // Registered pin drive
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic                  term_cnt;
    logic                  last_digit;
    logic                  wrap;

    logic [DIGITS-1:0]     lz_blank;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [DIGITS-1:0]     an_raw;
    logic [7:0]            seg_raw;

    // Active-high glyph for one nibble; 10..15 become letters or a dash.
    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = hex ? 7'h77 : 7'h40;
            4'hB:    g = hex ? 7'h7C : 7'h40;
            4'hC:    g = hex ? 7'h39 : 7'h40;
            4'hD:    g = hex ? 7'h5E : 7'h40;
            4'hE:    g = hex ? 7'h79 : 7'h40;
            default: g = hex ? 7'h71 : 7'h40;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    assign term_cnt   = (presc_q == PRESC_MAX);
    assign last_digit = (idx_q == IDX_MAX);
    assign wrap       = term_cnt && last_digit;

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (term_cnt) begin
            presc_d = '0;
            // With DIGITS=1 last_digit is always true, so the index stays 0.
            idx_d   = last_digit ? '0 : idx_q + IW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pending / active buffers
    // ------------------------------------------------------------------
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pending_d  = pending_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;

        // Promotion uses the registered pending data, so a load on the wrap
        // cycle promotes the older data and parks the new data for next frame.
        if (wrap && pending_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
            pending_d = 1'b0;
        end

        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_mask;
            pending_d  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero map: digit i blanks when it and every higher nibble is 0.
    // A decimal-mode nibble >9 is non-zero here, so it stops the blanking.
    // ------------------------------------------------------------------
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_blank = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero    = all_zero && (act_val_q[4*i +: 4] == 4'h0);
            lz_blank[i] = all_zero;
        end
        lz_blank[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Current-digit select and output encode
    // ------------------------------------------------------------------
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_raw    = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = act_val_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = blank_lz && lz_blank[i];
                an_raw[i] = 1'b1;
            end
        end
    end

    always_comb begin
        // dp is driven even on a blanked digit.
        seg_raw = {cur_dp, cur_blank ? 7'h00 : glyph(cur_nib, hex_mode)};
        seg_d   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        an_d    = AN_ACTIVE_LOW ? ~an_raw : an_raw;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pending_q  <= 1'b0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= SEG_RESET;
            an_q       <= AN_RESET;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pending_q  <= pending_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    // Decoded from registers only; low in reset because REFRESH_DIV >= 2.
    assign frame_done = wrap;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIGITS=4, REFRESH_DIV=4, both outputs active-low.
// t counts rising edges since reset release; outputs are sampled on the falling
// edge. Digit d of frame f first appears on seg at t = f*16 + d*4 + 1.

module tb_seg7_scan_driver;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned RDIV   = 4;
    localparam int unsigned FRAME  = DIGITS * RDIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        hex_mode;
    logic        blank_lz;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    typedef struct {
        int         due;
        logic [7:0] seg;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   t           = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS        (DIGITS),
        .REFRESH_DIV   (RDIV),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value     (value),
        .dp_mask   (dp_mask),
        .hex_mode  (hex_mode),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done),
        .pending   (pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Digit expected on an at sample t (one cycle behind the index).
    function automatic logic [3:0] an_exp(input int tt);
        int         d;
        logic [3:0] oh;
        d  = (tt == 0) ? 0 : ((tt - 1) / int'(RDIV)) % int'(DIGITS);
        oh = 4'b0001 << d;
        return ~oh;
    endfunction

    task automatic push_one(input int f, input int d, input logic [7:0] s, input string tag);
        exp_t e;
        e.due = f * int'(FRAME) + d * int'(RDIV) + 1;
        e.seg = s;
        e.tag = $sformatf("%s f%0d d%0d", tag, f, d);
        sb.push_back(e);
    endtask

    task automatic push_frame(input int f, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3, input string tag);
        push_one(f, 0, s0, tag);
        push_one(f, 1, s1, tag);
        push_one(f, 2, s2, tag);
        push_one(f, 3, s3, tag);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        t++;
        chk($sformatf("an t=%0d", t), {28'h0, an}, {28'h0, an_exp(t)});
        chk($sformatf("frame_done t=%0d", t), {31'h0, frame_done},
            {31'h0, (t % int'(FRAME)) == int'(FRAME) - 1});
        while (sb.size() > 0 && sb[0].due <= t) begin
            e = sb.pop_front();
            if (e.due < t) chk({e.tag, " missed"}, t, e.due);
            else           chk(e.tag, {24'h0, seg}, {24'h0, e.seg});
        end
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        load    = 1'b1;
        value   = v;
        dp_mask = dp;
        tick();
        load    = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " seg"}, {24'h0, seg}, 32'hC0);
        chk({tag, " an"}, {28'h0, an}, 32'hE);
        chk({tag, " frame_done"}, {31'h0, frame_done}, 32'h0);
        chk({tag, " pending"}, {31'h0, pending}, 32'h0);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        dp_mask  = 4'h0;
        hex_mode = 1'b1;
        blank_lz = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        t     = 0;
        chk_reset_outputs("release");

        // Idle scan, two full frames of '0'.
        push_frame(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "idle");
        push_frame(1, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "idle");
        run_to(32);

        // Load 1234 with dp on digit 2 while digit 1 is being scanned.
        push_one(2, 2, 8'hC0, "preload");
        push_one(2, 3, 8'hC0, "preload");
        run_to(37);
        do_load(16'h1234, 4'b0100);
        chk("pending after load", {31'h0, pending}, 32'h1);
        push_frame(3, 8'h99, 8'hB0, 8'h24, 8'hF9, "v1234");
        push_frame(4, 8'h99, 8'hB0, 8'h24, 8'hF9, "v1234");
        run_to(47);
        chk("pending at wrap", {31'h0, pending}, 32'h1);
        tick();
        chk("pending after wrap", {31'h0, pending}, 32'h0);
        run_to(64);

        // Hex letters, then the same value in decimal mode.
        do_load(16'h00AF, 4'b0000);
        push_frame(5, 8'h8E, 8'h88, 8'hC0, 8'hC0, "hexAF");
        push_frame(6, 8'hBF, 8'hBF, 8'hC0, 8'hC0, "decAF");
        run_to(96);
        hex_mode = 1'b0;
        push_frame(7, 8'hBF, 8'hBF, 8'hFF, 8'hFF, "lz_decAF");
        run_to(112);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0005, 4'b0000);
        push_frame(8, 8'h92, 8'hFF, 8'hFF, 8'hFF, "lz0005");
        run_to(128);
        do_load(16'h0000, 4'b0000);
        push_frame(9, 8'hC0, 8'hFF, 8'hFF, 8'hFF, "lz0000");
        run_to(160);

        // Load A mid-frame, then load B exactly on the wrap cycle.
        hex_mode = 1'b1;
        blank_lz = 1'b0;
        push_frame(10, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "zero");
        run_to(165);
        do_load(16'h5678, 4'b0001);
        chk("pending A", {31'h0, pending}, 32'h1);
        run_to(175);
        do_load(16'hC0DE, 4'b1000);
        chk("pending B at wrap", {31'h0, pending}, 32'h1);
        push_frame(11, 8'h00, 8'hF8, 8'h82, 8'h92, "A5678");
        push_one(12, 0, 8'h86, "BC0DE");
        push_one(12, 1, 8'hA1, "BC0DE");
        push_one(12, 2, 8'hC0, "BC0DE");
        run_to(191);
        chk("pending B held", {31'h0, pending}, 32'h1);
        tick();
        chk("pending B promoted", {31'h0, pending}, 32'h0);
        run_to(196);
        do_load(16'h1111, 4'b1111);
        chk("pending before reset", {31'h0, pending}, 32'h1);
        run_to(201);

        // Asynchronous reset while digit 2 is scanned.
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        chk_reset_outputs("reset_hold");
        rst_n = 1'b1;
        t     = 0;
        chk_reset_outputs("re_release");
        push_frame(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, "post_reset");
        run_to(20);
        chk("pending post reset", {31'h0, pending}, 32'h0);
        chk("scoreboard drained", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Multiplexed N-digit 7-segment display driver for the DTH11 sensor readout path.
- Successor to the single-digit 4-bit to 8-bit segment encoder. Adds:
  - parametrised digit count
  - time-multiplexed digit scanning
  - per-digit decimal point
  - hex/decimal mode and leading-zero blanking
  - tear-free value update at frame boundaries
- Sits between the sensor data formatter (packed BCD/hex nibbles) and the board segment/anode pins.

Parameters:
- DIGITS, 4, number of digits scanned; valid range 1..8.
- REFRESH_DIV, 100000, clock cycles each digit is lit; must be >= 2.
- SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (common-anode board), 0 = active-high.
- AN_ACTIVE_LOW, 1, 1 = digit enable outputs active-low.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- load, input, 1, single-cycle strobe: capture value/dp_mask into the pending register.
- value, input, 4*DIGITS, packed nibbles; nibble 0 (bits [3:0]) is the rightmost digit.
- dp_mask, input, DIGITS, per-digit decimal point request; bit i applies to digit i.
- hex_mode, input, 1, 1 = nibbles 10..15 shown as A,b,C,d,E,F; 0 = shown as dash.
- blank_lz, input, 1, 1 = blank leading zero digits.
- seg, output, 8, segment drive; bit0=a ... bit6=g, bit7=dp.
- an, output, DIGITS, one-hot digit enable.
- frame_done, output, 1, one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.
- pending, output, 1, high while a loaded value is waiting for the next frame boundary.

Behaviour:
- Reset (async, rst_n low): values while in reset and on the first cycle after release:
  - active value = 0, active dp = 0, pending register = 0, pending = 0
  - prescaler = 0, digit index = 0, frame_done = 0
  - an = digit 0 enabled (AN_ACTIVE_LOW=1 gives 4'b1110 for DIGITS=4)
  - seg = glyph '0' = 8'h3F active-high, 8'hC0 with SEG_ACTIVE_LOW=1
- Prescaler:
  - Counts 0..REFRESH_DIV-1. At terminal count it returns to 0 and the digit index increments.
  - Index wraps DIGITS-1 to 0.
  - For DIGITS=1 the index stays 0 and frame_done still pulses every REFRESH_DIV cycles.
- Outputs: seg and an are registered and update on the clock edge after the index change (one-cycle latency). an is always exactly one-hot (or one-cold); never zero or multiple active.
- Load and pending:
  - load=1 captures value and dp_mask into the pending register and sets pending=1.
  - A later load before the boundary overwrites the pending data (last load wins).
- Frame boundary:
  - On the cycle the index wraps to 0: if pending=1, pending data is copied to active and pending clears.
  - The new value is therefore first displayed on digit 0 of the new frame.
  - If load coincides with the wrap cycle, the old pending data transfers to active, and the new data is captured into pending with pending staying 1.
- frame_done: asserted for exactly one cycle, aligned with the wrap cycle.
- Glyphs (active-high, before polarity):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
  - A:77 b:7C C:39 d:5E E:79 F:71
  - dash:40, blank:00
- Decimal mode (hex_mode=0): nibble 10..15 shows dash.
- Leading-zero blanking (blank_lz=1): digit i is blanked if its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - In decimal mode a nibble >9 counts as non-zero.
- seg[7] = active dp bit of the current digit, independent of blanking.
- hex_mode and blank_lz are sampled live, not latched by load.
- Polarity: SEG_ACTIVE_LOW/AN_ACTIVE_LOW invert the final registered outputs only.

Test Plan:
- Reset scan (DIGITS=4, REFRESH_DIV=4, both active-low), no load:
  - release rst_n -> an cycles 1110,1101,1011,0111 each held 4 cycles, seg=C0 throughout
  - frame_done pulses every 16 cycles.
- Load mid-frame: load value=16'h1234, dp_mask=4'b0100 at digit index 1:
  - pending=1 until wrap; display stays '0000' through the current frame
  - next frame shows digit0=4 (66), digit1=3 (4F), digit2=2 with dp (DB), digit3=1 (06), all inverted on seg
  - pending=0 after wrap.
- Hex vs decimal: value=16'h00AF with hex_mode=1:
  - digit0=71, digit1=77
  - with hex_mode=0 -> both show 40.
- Leading-zero blanking: value=16'h0005, blank_lz=1 -> digits3..1 seg=00 active-high (FF inverted), digit0=6D; value=16'h0000 -> only digit0 lit with 3F.
- Simultaneous load and wrap: load A on an earlier cycle, then load B exactly on the wrap cycle:
  - A displayed in the next frame
  - pending stays 1 through it; B displayed in the following frame.
- Mid-operation reset: assert rst_n low during digit index 2 with value loaded -> outputs immediately return to the reset values; after release the display shows '0' and pending=0.
